// File: rtl/data_mem_pkg.sv
// Shared types and widths for the data-memory responder.
// The address and data are 64 bits wide, and the wait counter is 4 bits wide.
package data_mem_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmr_storage.sv
// DEPTH_WORDS x 64-bit word array.
// Writes are synchronous. Reads are combinational by index.
// The array has no reset, so its contents survive a system reset.
module dmr_storage
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Commit a store word at the clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the CPU load/store port.
// A request is latched in IDLE. The responder then waits WAIT_STATES cycles,
// and answers with a one-cycle ready pulse in RESP.
// Optional feature macro: DATA_MEM_ERR_EN. When it is defined, misaligned,
// out-of-range or dual-strobe requests are rejected and flagged with addr_error.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              ready,
  output logic              busy,
  output logic              addr_error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               wr_q;
  logic               err_q;

  logic               req;
  logic [IDX_W-1:0]   req_idx;
  logic               req_err;
  logic [IDX_W-1:0]   rd_idx;
  logic [DATA_W-1:0]  rd_data;
  logic               mem_we;

  assign req     = memRead || memWrite;
  assign req_idx = address[3 +: IDX_W];

`ifdef DATA_MEM_ERR_EN
  assign req_err = (address[2:0] != 3'd0)
                || (address[ADDR_W-1:3+IDX_W] != '0)
                || (memRead && memWrite);
`else
  // The low byte-offset bits and the upper bits are dropped, so the index wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[ADDR_W-1:3+IDX_W], address[2:0]};
  assign req_err = 1'b0;
`endif

  // With zero wait states, RESP is entered directly from IDLE, before the latches
  // hold the request. In that case the read uses the live index.
  assign rd_idx = (state == IDLE) ? req_idx : idx_q;

  // Reset in the RESP cycle blocks the commit.
  assign mem_we = (state == RESP) && wr_q && !err_q && !reset;

  dmr_storage #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_storage (
    .clk  (clk),
    .we   (mem_we),
    .widx (idx_q),
    .wdata(wdata_q),
    .ridx (rd_idx),
    .rdata(rd_data)
  );

  // Capture the request fields when a strobe is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      idx_q   <= req_idx;
      wdata_q <= write_data;
      wr_q    <= memWrite;
      err_q   <= req_err;
    end
  end

  // Request FSM with registered ready, busy, addr_error and read_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      addr_error <= 1'b0;
      read_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready      <= 1'b0;
          addr_error <= 1'b0;
          if (req) begin
            busy <= 1'b1;
            if (WAIT_STATES > 0) begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end else begin
              state      <= RESP;
              ready      <= 1'b1;
              addr_error <= req_err;
              if (!memWrite && !req_err) begin
                read_data <= rd_data;
              end
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            ready      <= 1'b1;
            addr_error <= err_q;
            if (!wr_q && !err_q) begin
              read_data <= rd_data;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          ready      <= 1'b0;
          busy       <= 1'b0;
          addr_error <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          ready      <= 1'b0;
          busy       <= 1'b0;
          addr_error <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder.
// Instance a uses WAIT_STATES=2 and instance b uses WAIT_STATES=0.
// Both instances share the clock and reset.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rd_a, wr_a, rdy_a, busy_a, err_a;
  logic [63:0] addr_a, wd_a, rdat_a;
  logic        rd_b, wr_b, rdy_b, busy_b, err_b;
  logic [63:0] addr_b, wd_b, rdat_b;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_dut_a (
    .clk(clk), .reset(reset), .memRead(rd_a), .memWrite(wr_a),
    .address(addr_a), .write_data(wd_a), .read_data(rdat_a),
    .ready(rdy_a), .busy(busy_a), .addr_error(err_a)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .reset(reset), .memRead(rd_b), .memWrite(wr_b),
    .address(addr_b), .write_data(wd_b), .read_data(rdat_b),
    .ready(rdy_b), .busy(busy_b), .addr_error(err_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, hold the strobe until ready is seen, then drop it.
  // lat counts clock edges from the sampling edge up to the edge that raises ready.
  task automatic run_req(input bit sel, input bit r, input bit w,
                         input logic [63:0] a, input logic [63:0] d,
                         output logic [63:0] rdat, output logic [63:0] pre_rdat,
                         output logic e, output int lat, output int bcnt);
    bit done;
    @(negedge clk);
    if (sel) begin rd_b = r; wr_b = w; addr_b = a; wd_b = d; end
    else     begin rd_a = r; wr_a = w; addr_a = a; wd_a = d; end
    lat = -1; bcnt = 0; done = 1'b0; e = 1'b0; rdat = '0;
    pre_rdat = sel ? rdat_b : rdat_a;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(posedge clk); #1;
      if (sel ? busy_b : busy_a) bcnt++;
      if (sel ? rdy_b : rdy_a) begin
        done = 1'b1;
        lat  = k;
        rdat = sel ? rdat_b : rdat_a;
        e    = sel ? err_b : err_a;
      end else begin
        pre_rdat = sel ? rdat_b : rdat_a;
      end
    end
    if (sel) begin rd_b = 1'b0; wr_b = 1'b0; end
    else     begin rd_a = 1'b0; wr_a = 1'b0; end
    @(posedge clk); #1;
    check(sel ? "b_ready_one_cycle" : "a_ready_one_cycle", sel ? rdy_b : rdy_a, 1'b0);
  endtask

  logic [63:0] rdat, pre;
  logic        e;
  int          lat, bcnt;

  initial begin
    reset = 1'b1;
    rd_a = 0; wr_a = 0; addr_a = '0; wd_a = '0;
    rd_b = 0; wr_b = 0; addr_b = '0; wd_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_a", rdy_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_err_a", err_a, 0);
    check("rst_rdata_a", rdat_a, 64'h0);
    check("rst_ready_b", rdy_b, 0);
    check("rst_busy_b", busy_b, 0);
    check("rst_rdata_b", rdat_b, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Write 0x10 with WAIT_STATES=2.
    run_req(0, 0, 1, 64'h10, 64'hDEADBEEF_CAFEF00D, rdat, pre, e, lat, bcnt);
    check("wr10_latency", lat, 3);
    check("wr10_busy_cycles", bcnt, 3);
    check("wr10_err", e, 0);

    // Read it back. read_data must change only in the ready cycle.
    run_req(0, 1, 0, 64'h10, 64'h0, rdat, pre, e, lat, bcnt);
    check("rd10_data", rdat, 64'hDEADBEEF_CAFEF00D);
    check("rd10_before_ready", pre, 64'h0);
    check("rd10_latency", lat, 3);
    check("rd10_err", e, 0);
    check("rd10_held", rdat_a, 64'hDEADBEEF_CAFEF00D);

    // Zero wait states, with a write and a read issued back to back.
    run_req(1, 0, 1, 64'h8, 64'd5, rdat, pre, e, lat, bcnt);
    check("b_wr8_latency", lat, 1);
    check("b_wr8_busy_cycles", bcnt, 1);
    run_req(1, 1, 0, 64'h8, 64'h0, rdat, pre, e, lat, bcnt);
    check("b_rd8_latency", lat, 1);
    check("b_rd8_data", rdat, 64'd5);

    // A write must not disturb read_data.
    run_req(0, 0, 1, 64'h18, 64'h5555_AAAA_0F0F_F0F0, rdat, pre, e, lat, bcnt);
    check("wr18_rdata_untouched", rdat_a, 64'hDEADBEEF_CAFEF00D);

    // Abort a write of 0x1234 to 0x18 with reset while in WAIT.
    @(negedge clk);
    wr_a = 1'b1; addr_a = 64'h18; wd_a = 64'h1234;
    @(posedge clk); #1;
    check("abort_busy_in_wait", busy_a, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", rdy_a, 0);
    check("abort_busy", busy_a, 0);
    @(negedge clk);
    reset = 1'b0; wr_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_ready", rdy_a, 0);
    end
    run_req(0, 1, 0, 64'h18, 64'h0, rdat, pre, e, lat, bcnt);
    check("rd18_old_value", rdat, 64'h5555_AAAA_0F0F_F0F0);

`ifdef DATA_MEM_ERR_EN
    // Rejected requests: misaligned, out of range, and both strobes high.
    run_req(0, 1, 0, 64'h13, 64'h0, rdat, pre, e, lat, bcnt);
    check("err13_flag", e, 1);
    check("err13_rdata", rdat, 64'h5555_AAAA_0F0F_F0F0);
    check("err13_latency", lat, 3);
    run_req(0, 1, 0, 64'h800, 64'h0, rdat, pre, e, lat, bcnt);
    check("err800_flag", e, 1);
    check("err800_rdata", rdat, 64'h5555_AAAA_0F0F_F0F0);
    run_req(0, 1, 1, 64'h10, 64'h1111, rdat, pre, e, lat, bcnt);
    check("errboth_flag", e, 1);
    check("errboth_rdata", rdat, 64'h5555_AAAA_0F0F_F0F0);
    run_req(0, 1, 0, 64'h10, 64'h0, rdat, pre, e, lat, bcnt);
    check("mem10_unchanged", rdat, 64'hDEADBEEF_CAFEF00D);
    check("mem10_err", e, 0);
`else
    // The index wraps: 0x808 and 0x8 select the same word.
    run_req(0, 0, 1, 64'h808, 64'd7, rdat, pre, e, lat, bcnt);
    check("wr808_err", e, 0);
    run_req(0, 1, 0, 64'h8, 64'h0, rdat, pre, e, lat, bcnt);
    check("rd8_wrap_data", rdat, 64'd7);
    check("rd8_wrap_err", e, 0);
    // Both strobes high counts as a write.
    run_req(0, 1, 1, 64'h30, 64'h42, rdat, pre, e, lat, bcnt);
    check("both_err", e, 0);
    run_req(0, 1, 0, 64'h30, 64'h0, rdat, pre, e, lat, bcnt);
    check("both_as_write", rdat, 64'h42);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Memory-side responder for the CPU's data-memory port. Answers the CPU's load and store strobes (memRead, memWrite) after a configurable number of wait states.
- Internal storage is a doubleword-addressed array. A one-cycle ready pulse closes each request, which lets the CPU core move from a single-cycle data memory to a multi-cycle stall-capable one.

## Interface
- DEPTH_WORDS, 256: number of 64-bit words; power of two, at least 2. IDX_W = log2(DEPTH_WORDS).
- WAIT_STATES, 2: cycles spent in WAIT before responding; 0..15 allowed.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- memRead  in  1  load request strobe.
- memWrite  in  1  store request strobe.
- address  in  64  byte address from the ALU result.
- write_data  in  64  store data (register file databus2).
- read_data  out  64  load result; valid while ready=1 for a read.
- ready  out  1  one-cycle response pulse; request complete.
- busy  out  1  high in WAIT and RESP; requests are not sampled.
- addr_error  out  1  high with ready when the request was rejected; stays low when DATA_MEM_ERR_EN is off.

## Operation
- FSM has three states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - If memRead or memWrite is high, latch address, write_data and op. Go to WAIT if WAIT_STATES > 0, else RESP. Load wait counter with WAIT_STATES-1.
  - Otherwise stay in IDLE.
- WAIT: decrement the counter each cycle; go to RESP when the counter is 0. Inputs are ignored.
- RESP:
  - ready=1 for exactly this cycle.
  - Write: commit latched data to mem[idx] at the end of this cycle.
  - Read: read_data = mem[idx].
  - Next state is always IDLE.
- Index: idx = latched address[3 +: IDX_W].
- Handshake rules:
  - The initiator holds its strobe until it samples ready=1, then drops it on that same edge.
  - A strobe still high in the IDLE cycle after RESP is a new request.
- read_data holds its last read value until the next read response. It is not updated by writes.
- Memory contents are not cleared by reset.

## Timing
- Request sampled at edge N in IDLE. ready is high from edge N+WAIT_STATES+1 to edge N+WAIT_STATES+2.
- Latency is WAIT_STATES+1 cycles. Back-to-back throughput is one request per WAIT_STATES+2 cycles.
- Read-after-write to the same index returns the new data, because the write commits in the earlier RESP.
- Reset values: ready=0, busy=0, addr_error=0, read_data=64'h0, state=IDLE, counter=0.
- Reset mid-operation (WAIT or RESP): the request is aborted, no write is committed, and no ready is issued. Reset asserted in the same cycle as the RESP commit blocks the commit.

## Configuration
- DATA_MEM_ERR_EN defined:
  - A request is rejected if address[2:0] != 0, if address[63:3+IDX_W] != 0, or if memRead and memWrite are both high.
  - Rejected requests run the normal FSM timing but perform no access. In RESP, addr_error=1, ready=1, and read_data is unchanged.
- DATA_MEM_ERR_EN undefined:
  - addr_error is tied to 0.
  - address[2:0] is ignored and the upper bits wrap, so the index is taken modulo DEPTH_WORDS.
  - Both strobes high is treated as a write.

## Structure
- Package data_mem_pkg holds:
  - the state typedef: IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - the 64-bit data/address width constants;
  - the wait-counter width (4 bits).
- Sub-module dmr_storage is the DEPTH_WORDS x 64 array: synchronous write enable and combinational read by index.
- The FSM, request latches and error check stay in the top level.

## Test plan
- Reset, then write address 0x10 with data 0xDEADBEEF_CAFEF00D (WAIT_STATES=2). ready pulses 3 cycles after sampling, addr_error=0, busy is high for 3 cycles.
- Read 0x10. read_data=0xDEADBEEF_CAFEF00D, valid exactly in the ready cycle, then held afterwards.
- WAIT_STATES=0: write 0x8=5 then read 0x8 back-to-back. Each ready arrives 1 cycle after sampling and the read returns 5.
- Assert reset during WAIT of a write of 0x1234 to 0x18, then read 0x18. The old value is returned and no ready occurs during the aborted request.
- With DATA_MEM_ERR_EN: read 0x13, read 0x800 (DEPTH=256), and both strobes high. Each gives ready=1 with addr_error=1, read_data is unchanged, and the memory is unchanged.
- Without DATA_MEM_ERR_EN: write 0x808=7, then read 0x8. The read returns 7 (wrap), and addr_error stays 0.
